// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM states and default width.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage : serial_sub_pkg

// File: rtl/serial_sub_full_subtractor.sv
// One-bit full subtractor: difference and borrow-out for a - b - bin.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Borrow is generated when a=0,b=1 and propagated when a==b.
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : full_subtractor

// File: rtl/serial_sub.sv
// Bit-serial subtractor: computes NumA - NumB one bit per cycle, LSB first,
// reporting the modular result, unsigned borrow and signed overflow.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             Start,
    input  logic [WIDTH-1:0] NumA,
    input  logic [WIDTH-1:0] NumB,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             Borrow,
    output logic             Overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    // Reset synchronizer: asserts immediately, releases two edges after nRST rises.
    logic [1:0] sync_reg;
    logic       rst_sync_n;

    // Assert asynchronously, deassert synchronously to CLK.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], 1'b1};
        end
    end

    assign rst_sync_n = sync_reg[1];

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res_reg;
    logic             bin_reg;
    logic [CW-1:0]    cnt_reg;
    logic [CW-1:0]    cnt_next;
    logic             last_bit;
    logic             a_msb_reg;
    logic             b_msb_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             borrow_reg;
    logic             ovf_reg;
    logic             d_bit;
    logic             bout_bit;

    // Single shared bit slice; operands are presented LSB first via right shifts.
    full_subtractor u_fs (
        .a    (a_reg[0]),
        .b    (b_reg[0]),
        .bin  (bin_reg),
        .d    (d_bit),
        .bout (bout_bit)
    );

    // Next-state logic: the last SHIFT cycle is the one whose count reaches WIDTH.
    always_comb begin
        cnt_next   = cnt_reg + 1'b1;
        last_bit   = (cnt_next == CW'(WIDTH));
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (Start) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM and datapath; flags are captured on the final SHIFT edge and held until the next Start.
    always_ff @(posedge CLK or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_reg  <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            res_reg    <= '0;
            bin_reg    <= 1'b0;
            cnt_reg    <= '0;
            a_msb_reg  <= 1'b0;
            b_msb_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            borrow_reg <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next == SHIFT);
            done_reg  <= (state_next == DONE);
            case (state_reg)
                IDLE: begin
                    if (Start) begin
                        a_reg     <= NumA;
                        b_reg     <= NumB;
                        a_msb_reg <= NumA[WIDTH-1];
                        b_msb_reg <= NumB[WIDTH-1];
                        bin_reg   <= 1'b0;
                        cnt_reg   <= '0;
                    end
                end
                SHIFT: begin
                    res_reg <= {d_bit, res_reg[WIDTH-1:1]};
                    a_reg   <= a_reg >> 1;
                    b_reg   <= b_reg >> 1;
                    bin_reg <= bout_bit;
                    cnt_reg <= cnt_next;
                    if (last_bit) begin
                        // d_bit is the result MSB on this final edge.
                        borrow_reg <= bout_bit;
                        ovf_reg    <= (a_msb_reg ^ b_msb_reg) & (a_msb_reg ^ d_bit);
                    end
                end
                default: ;
            endcase
        end
    end

    assign Busy     = busy_reg;
    assign Done     = done_reg;
    assign Result   = res_reg;
    assign Borrow   = borrow_reg;
    assign Overflow = ovf_reg;

endmodule : serial_sub

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub (WIDTH=8): directed cases plus random operands
// compared against an arithmetic reference model.
module tb_serial_sub;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         nRST = 1'b0;
    logic         Start = 1'b0;
    logic [W-1:0] NumA = '0;
    logic [W-1:0] NumB = '0;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Result;
    logic         Borrow;
    logic         Overflow;

    int errors = 0;
    int checks = 0;

    serial_sub #(.WIDTH(W)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .Start    (Start),
        .NumA     (NumA),
        .NumB     (NumB),
        .Busy     (Busy),
        .Done     (Done),
        .Result   (Result),
        .Borrow   (Borrow),
        .Overflow (Overflow)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic void model(input int a, input int b,
                                  output int r, output int br, output int ov);
        int sa, sb, sd;
        r  = (a - b) & 255;
        br = (a < b) ? 1 : 0;
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        sd = sa - sb;
        ov = (sd > 127 || sd < -128) ? 1 : 0;
    endfunction

    // One operation: pulse Start, scramble inputs afterwards, wait for Done (bounded).
    task automatic do_op(input int a, input int b, input string tag);
        int edges;
        int r, br, ov;
        model(a, b, r, br, ov);
        @(negedge CLK);
        Start = 1'b1;
        NumA  = W'(a);
        NumB  = W'(b);
        @(negedge CLK);
        Start = 1'b0;
        NumA  = W'($urandom);
        NumB  = W'($urandom);
        edges = 1;
        check({tag, "_busy"}, 32'(Busy), 32'd1);
        while (!Done && edges < 40) begin
            @(negedge CLK);
            edges++;
            NumA = W'($urandom);
            NumB = W'($urandom);
        end
        // The accepting edge counts as the first of the W+1 edges.
        check({tag, "_latency"}, 32'(edges), 32'(W + 1));
        check({tag, "_result"}, 32'(Result), 32'(r));
        check({tag, "_borrow"}, 32'(Borrow), 32'(br));
        check({tag, "_ovf"}, 32'(Overflow), 32'(ov));
        $display("op %s: %02h-%02h -> %02h b=%0d v=%0d (%0d edges)",
                 tag, a, b, Result, Borrow, Overflow, edges);
        @(negedge CLK);
        check({tag, "_done_pulse"}, 32'(Done), 32'd0);
        check({tag, "_hold"}, 32'(Result), 32'(r));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int done_cnt;
        int cap;
        int last_done;
        int pulses;

        // Reset and release; allow the synchronizer to let go.
        repeat (3) @(negedge CLK);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_result", 32'(Result), 32'd0);
        check("rst_borrow", 32'(Borrow), 32'd0);
        check("rst_ovf", 32'(Overflow), 32'd0);
        nRST = 1'b1;
        repeat (3) @(negedge CLK);

        do_op(8'h05, 8'h03, "d05_03");
        do_op(8'h03, 8'h05, "d03_05");
        do_op(8'h80, 8'h01, "d80_01");

        // Start re-pulsed during SHIFT must be ignored.
        @(negedge CLK);
        Start = 1'b1; NumA = 8'h10; NumB = 8'h01;
        @(negedge CLK);
        Start = 1'b0;
        @(negedge CLK);
        Start = 1'b1; NumA = 8'hFF; NumB = 8'h00;
        @(negedge CLK);
        Start = 1'b0;
        done_cnt = 0;
        cap = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge CLK);
            if (Done) begin
                done_cnt++;
                cap = int'(Result);
            end
        end
        check("repulse_done_count", 32'(done_cnt), 32'd1);
        check("repulse_result", 32'(cap), 32'h0F);
        $display("op repulse: 10-01 -> %02h, done pulses=%0d", cap, done_cnt);

        // Start held high: back-to-back operations every W+2 cycles.
        @(negedge CLK);
        Start = 1'b1; NumA = 8'h00; NumB = 8'h00;
        last_done = -1;
        pulses = 0;
        for (int i = 0; i < 45 && pulses < 4; i++) begin
            @(negedge CLK);
            if (Done) begin
                if (last_done >= 0) check("b2b_period", 32'(i - last_done), 32'(W + 2));
                check("b2b_result", {Result, 7'd0, Borrow, 7'd0, Overflow}, 32'd0);
                last_done = i;
                pulses++;
            end
        end
        check("b2b_pulses", 32'(pulses), 32'd4);
        $display("op back_to_back: %0d Done pulses", pulses);
        Start = 1'b0;
        repeat (12) @(negedge CLK);

        // Asynchronous reset mid-SHIFT.
        @(negedge CLK);
        Start = 1'b1; NumA = 8'h55; NumB = 8'h22;
        @(negedge CLK);
        Start = 1'b0;
        repeat (3) @(negedge CLK);
        #2;
        nRST = 1'b0;
        #1;
        check("async_busy", 32'(Busy), 32'd0);
        check("async_result", 32'(Result), 32'd0);
        check("async_flags", {Done, Borrow, Overflow}, 32'd0);
        done_cnt = 0;
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge CLK);
            if (Done) done_cnt++;
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        $display("op abort: reset mid-SHIFT, done pulses=%0d", done_cnt);
        do_op(8'h7F, 8'h80, "d7F_80");

        // Randomized operands against the reference model.
        for (int n = 0; n < 1000; n++) begin
            do_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), $sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_serial_sub
